// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in while gate is high and
// latches the count when gate falls. Optional build macro FREQ_AVG4_EN: 4-window running average.
module freq_meter #(
    parameter int CNT_W       = 25,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             gate,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             ovf,
    output logic             busy
);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } win_t;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        COUNT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d;
    logic                   sig_edge;
    logic                   gate_d;
    logic                   gate_rise;
    logic                   gate_fall;
    state_t                 state;
    state_t                 state_nxt;
    logic                   win_start;
    logic                   win_done;
    logic [CNT_W-1:0]       cnt;
    logic                   sat_flag;
    win_t                   win_res;

    // sig_in crosses domains here; only the last stage feeds the edge detector
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_edge = sync_q[SYNC_STAGES-1] & ~sig_d;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) gate_d <= 1'b0;
        else     gate_d <= gate;
    end

    assign gate_rise = gate & ~gate_d;
    assign gate_fall = ~gate & gate_d;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= WAIT_LOW;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        win_start = 1'b0;
        win_done  = 1'b0;
        case (state)
            WAIT_LOW: if (!gate) state_nxt = ARMED;
            ARMED: begin
                if (gate_rise) begin
                    win_start = 1'b1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (gate_fall) begin
                    win_done  = 1'b1;
                    state_nxt = ARMED;
                end
            end
            default: state_nxt = WAIT_LOW;
        endcase
    end

    assign busy = (state == COUNT);

    // Saturating edge counter; an edge in the fall cycle is deliberately ignored
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else if (win_start) begin
            cnt      <= {{(CNT_W-1){1'b0}}, sig_edge};
            sat_flag <= 1'b0;
        end else if (win_done) begin
            sat_flag <= 1'b0;
        end else if (state == COUNT && gate && sig_edge) begin
            if (cnt == CNT_MAX) sat_flag <= 1'b1;
            else                cnt      <= cnt + 1'b1;
        end
    end

    assign win_res = '{cnt: cnt, sat: sat_flag};

`ifdef FREQ_AVG4_EN
    localparam int STAGES = 1;

    logic [STAGES:0]  vld_pipe;
    win_t [3:0]       hist;
    logic [1:0]       nwin;
    logic [CNT_W+1:0] sum;
    logic             hist_sat;

    // nwin saturates at 3: "three windows already stored" gates the output pulse
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            hist <= '0;
            nwin <= 2'd0;
        end else if (win_done) begin
            hist <= {hist[2:0], win_res};
            if (nwin != 2'd3) nwin <= nwin + 2'd1;
        end
    end

    assign sum = {2'b00, hist[0].cnt} + {2'b00, hist[1].cnt}
               + {2'b00, hist[2].cnt} + {2'b00, hist[3].cnt};
    assign hist_sat = hist[0].sat | hist[1].sat | hist[2].sat | hist[3].sat;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            freq_count <= '0;
            ovf        <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], win_done && nwin == 2'd3};
            if (vld_pipe[0]) begin
                freq_count <= CNT_W'(sum >> 2);
                ovf        <= hist_sat;
            end
        end
    end

    assign freq_valid = vld_pipe[STAGES];
`else
    localparam int STAGES = 0;

    logic [STAGES:0] vld_pipe;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            freq_count <= '0;
            ovf        <= 1'b0;
        end else begin
            vld_pipe[0] <= win_done;
            if (win_done) begin
                freq_count <= win_res.cnt;
                ovf        <= win_res.sat;
            end
        end
    end

    assign freq_valid = vld_pipe[STAGES];
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 25-bit instance and a 4-bit instance share all stimulus.
module tb_freq_meter;

    logic        clock;
    logic        rst;
    logic        gate;
    logic        sig_in;
    logic [24:0] freq_count;
    logic        freq_valid;
    logic        ovf;
    logic        busy;
    logic [3:0]  freq_count4;
    logic        freq_valid4;
    logic        ovf4;
    logic        busy4;

    int tests_run = 0;
    int tests_failed = 0;
    int vcnt = 0;
    int vcnt4 = 0;
    int sig_period = 0;
    logic sig_hold = 1'b0;

    freq_meter #(.CNT_W(25), .SYNC_STAGES(2)) dut (
        .clock(clock), .rst(rst), .gate(gate), .sig_in(sig_in),
        .freq_count(freq_count), .freq_valid(freq_valid), .ovf(ovf), .busy(busy)
    );

    freq_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clock(clock), .rst(rst), .gate(gate), .sig_in(sig_in),
        .freq_count(freq_count4), .freq_valid(freq_valid4), .ovf(ovf4), .busy(busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (freq_valid === 1'b1) vcnt++;
        if (freq_valid4 === 1'b1) vcnt4++;
    end

    // Square wave: high for the first half of each period (period 0 holds sig_hold)
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (sig_period == 0) begin
                sig_in = sig_hold;
                ph = 0;
            end else begin
                ph = ph + 1;
                if (ph >= sig_period) ph = 0;
                sig_in = (ph < sig_period / 2);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Gate high for n clocks, then return just after the fall edge (freq_valid cycle)
    task automatic run_window(input int n);
        gate = 1'b1;
        repeat (n) tick();
        gate = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gate = 1'b1;
        sig_period = 10;
        repeat (5) tick();
        tests_run++;
        if ({freq_count, freq_valid, ovf, busy} !== 28'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got cnt=%0d v=%b ovf=%b busy=%b, want all 0",
                     freq_count, freq_valid, ovf, busy);
        end
        rst = 1'b0;
        repeat (20) tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL partial_window_busy: got %b want 0", busy);
        end
        gate = 1'b0;
        repeat (10) tick();
        tests_run++;
        if (vcnt !== 0) begin
            tests_failed++;
            $display("FAIL partial_window_valid: got %0d pulses want 0", vcnt);
        end
    endtask

    task automatic test_count();
        int v0;
        sig_period = 10;
        repeat (30) tick();
        v0 = vcnt;
        gate = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL count_busy: got %b want 1", busy);
        end
        repeat (24999) tick();
        gate = 1'b0;
        tick();
        tests_run++;
        if (freq_valid !== 1'b1 || freq_count !== 25'd2500 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL count_2500: got v=%b cnt=%0d ovf=%b want v=1 cnt=2500 ovf=0",
                     freq_valid, freq_count, ovf);
        end
        tick();
        tests_run++;
        if (freq_valid !== 1'b0 || freq_count !== 25'd2500 || busy !== 1'b0 || vcnt - v0 !== 1) begin
            tests_failed++;
            $display("FAIL count_hold: got v=%b cnt=%0d busy=%b pulses=%0d want v=0 cnt=2500 busy=0 pulses=1",
                     freq_valid, freq_count, busy, vcnt - v0);
        end
    endtask

    task automatic test_static();
        for (int lvl = 0; lvl < 2; lvl++) begin
            sig_period = 0;
            sig_hold = lvl[0];
            repeat (30) tick();
            run_window(200);
            tests_run++;
            if (freq_valid !== 1'b1 || freq_count !== 25'd0 || ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL static_%0d: got v=%b cnt=%0d ovf=%b want v=1 cnt=0 ovf=0",
                         lvl, freq_valid, freq_count, ovf);
            end
            tick();
        end
    endtask

    task automatic test_glitch();
        sig_period = 0;
        sig_hold = 1'b0;
        repeat (10) tick();
        run_window(1);
        tests_run++;
        if (freq_valid !== 1'b1 || freq_count !== 25'd0) begin
            tests_failed++;
            $display("FAIL glitch_window: got v=%b cnt=%0d want v=1 cnt=0", freq_valid, freq_count);
        end
        tick();
    endtask

    task automatic test_saturate();
        sig_period = 4;
        repeat (30) tick();
        run_window(100);
        tests_run++;
        if (freq_valid4 !== 1'b1 || freq_count4 !== 4'd15 || ovf4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_cnt4: got v=%b cnt=%0d ovf=%b want v=1 cnt=15 ovf=1",
                     freq_valid4, freq_count4, ovf4);
        end
        tests_run++;
        if (freq_count !== 25'd25 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_wide25: got cnt=%0d ovf=%b want cnt=25 ovf=0", freq_count, ovf);
        end
        tick();
        sig_period = 20;
        repeat (30) tick();
        run_window(100);
        tests_run++;
        if (freq_valid4 !== 1'b1 || freq_count4 !== 4'd5 || ovf4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_recover: got v=%b cnt=%0d ovf=%b want v=1 cnt=5 ovf=0",
                     freq_valid4, freq_count4, ovf4);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        sig_period = 10;
        repeat (30) tick();
        run_window(100);
        tests_run++;
        if (freq_valid !== 1'b1 || freq_count !== 25'd10) begin
            tests_failed++;
            $display("FAIL b2b_first: got v=%b cnt=%0d want v=1 cnt=10", freq_valid, freq_count);
        end
        run_window(50);
        tests_run++;
        if (freq_valid !== 1'b1 || freq_count !== 25'd5) begin
            tests_failed++;
            $display("FAIL b2b_second: got v=%b cnt=%0d want v=1 cnt=5", freq_valid, freq_count);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        int v0;
        sig_period = 10;
        repeat (30) tick();
        gate = 1'b1;
        repeat (50) tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (freq_count !== 25'd0 || freq_count4 !== 4'd0 || busy !== 1'b0 ||
            freq_valid !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async: got cnt=%0d cnt4=%0d busy=%b v=%b ovf=%b want all 0",
                     freq_count, freq_count4, busy, freq_valid, ovf);
        end
        v0 = vcnt;
        tick();
        rst = 1'b0;
        repeat (50) tick();
        gate = 1'b0;
        repeat (10) tick();
        tests_run++;
        if (vcnt !== v0 || freq_count !== 25'd0) begin
            tests_failed++;
            $display("FAIL rst_discard: got pulses=%0d cnt=%0d want pulses=0 cnt=0", vcnt - v0, freq_count);
        end
        run_window(100);
        tests_run++;
        if (freq_valid !== 1'b1 || freq_count !== 25'd10 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_recover: got v=%b cnt=%0d ovf=%b want v=1 cnt=10 ovf=0",
                     freq_valid, freq_count, ovf);
        end
        tick();
    endtask

    task automatic test_avg4();
        rst = 1'b1;
        gate = 1'b0;
        sig_period = 10;
        repeat (5) tick();
        rst = 1'b0;
        repeat (30) tick();
        for (int w = 1; w <= 3; w++) begin
            run_window(1000 * w);
            tick();
        end
        tests_run++;
        if (vcnt !== 0) begin
            tests_failed++;
            $display("FAIL avg_early: got %0d pulses want 0", vcnt);
        end
        run_window(4000);
        tests_run++;
        if (freq_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL avg_latency: got v=%b want 0 one cycle after fall", freq_valid);
        end
        tick();
        tests_run++;
        if (freq_valid !== 1'b1 || freq_count !== 25'd250 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL avg_4th: got v=%b cnt=%0d ovf=%b want v=1 cnt=250 ovf=0",
                     freq_valid, freq_count, ovf);
        end
        tick();
        run_window(5000);
        tick();
        tests_run++;
        if (freq_valid !== 1'b1 || freq_count !== 25'd350) begin
            tests_failed++;
            $display("FAIL avg_5th: got v=%b cnt=%0d want v=1 cnt=350", freq_valid, freq_count);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        gate = 1'b0;
`ifdef FREQ_AVG4_EN
        test_avg4();
`else
        test_reset();
        test_count();
        test_static();
        test_glitch();
        test_saturate();
        test_back_to_back();
        test_rst_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
